// File: rtl/hs_ram_arbiter_pkg.sv
// Shared types and defaults for the hiscore/CPU work-RAM arbiter.
package hs_arb_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        SETTLE  = 3'd2,
        GRANT   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // 10 s of paused time at 48 MHz
    localparam logic [31:0] DIM_CYC_DEFAULT = 32'h1C9C_3800;

endpackage

// File: rtl/hs_ram_arbiter_pause_dim_timer.sv
// Saturating paused-time counter that raises the video dim flag after DIM_CYC paused cycles.
module pause_dim_timer #(
    parameter logic [31:0] DIM_CYC = 32'h1C9C_3800
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pause,
    output logic dim_video
);

    logic [31:0] timer_r;
    logic        dim_r;

    // Count paused cycles, hold at the limit, clear as soon as the core runs again.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer_r <= 32'd0;
            dim_r   <= 1'b0;
        end else begin
            if (!pause) begin
                timer_r <= 32'd0;
            end else if (timer_r < DIM_CYC) begin
                timer_r <= timer_r + 32'd1;
            end else begin
                timer_r <= DIM_CYC;
            end
            dim_r <= (timer_r >= DIM_CYC);
        end
    end

    assign dim_video = dim_r;

endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the game work-RAM port between CPU and hiscore engine and owns the core pause request.
// Optional feature: define PAUSE_DIM_EN to dim the video after a long pause.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 8,
    parameter int          SETTLE_CYC = 4,
    parameter logic [31:0] DIM_CYC    = DIM_CYC_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              m_pause,
    input  logic              osd_open,
    input  logic              osd_pause_en,
    input  logic              vblank,
    input  logic              hs_req,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_wdata,
    input  logic              hs_we,
    output logic              hs_gnt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              pause,
    output logic              dim_video
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state_r;
    logic [3:0] settle_cnt_r;
    logic       hs_gnt_r;
    logic       m_pause_prev_r;
    logic       toggle_r;
    logic       pause_r;
    logic       hs_access_s;

    assign hs_access_s = (state_r != RUN);

    // Ownership sequencer: wait for vblank, let the CPU settle, then hand over the port.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= RUN;
            settle_cnt_r <= 4'd0;
            hs_gnt_r     <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hs_req) state_r <= DRAIN;
                end
                DRAIN: begin
                    if (!hs_req) begin
                        state_r <= RUN;
                    end else if (vblank) begin
                        settle_cnt_r <= SETTLE_LOAD;
                        state_r      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!hs_req) begin
                        state_r <= RUN;
                    end else if (settle_cnt_r == 4'd0) begin
                        state_r  <= GRANT;
                        hs_gnt_r <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                GRANT: begin
                    if (!hs_req) begin
                        state_r  <= RELEASE;
                        hs_gnt_r <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r  <= RUN;
                    hs_gnt_r <= 1'b0;
                end
            endcase
        end
    end

    // Pause request: hiscore access, user toggle, or OSD hold.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            m_pause_prev_r <= 1'b0;
            toggle_r       <= 1'b0;
            pause_r        <= 1'b0;
        end else begin
            m_pause_prev_r <= m_pause;
            if (m_pause && !m_pause_prev_r) begin
                toggle_r <= ~toggle_r;
            end
            pause_r <= hs_access_s | toggle_r | (osd_open & osd_pause_en);
        end
    end

    // Port mux follows the registered state; writes are blocked outside RUN/GRANT and during reset.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (state_r == GRANT) begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
        if (reset) begin
            ram_we = 1'b0;
        end else begin
            case (state_r)
                RUN:     ram_we = cpu_we;
                GRANT:   ram_we = hs_we & hs_gnt_r;
                default: ram_we = 1'b0;
            endcase
        end
    end

    assign hs_gnt = hs_gnt_r;
    assign pause  = pause_r;

`ifdef PAUSE_DIM_EN
    pause_dim_timer #(
        .DIM_CYC(DIM_CYC)
    ) u_pause_dim_timer (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .pause    (pause_r),
        .dim_video(dim_video)
    );
`else
    assign dim_video = 1'b0;
`endif

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: directed plan steps, then randomized traffic against a timestamp model.
module tb_hs_ram_arbiter;

    localparam int SETTLE = 4;
    localparam int DIM    = 20;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        m_pause = 1'b0, osd_open = 1'b0, osd_pause_en = 1'b0, vblank = 1'b0;
    logic        hs_req = 1'b0, hs_we = 1'b0, cpu_we = 1'b0;
    logic [15:0] hs_addr = 16'h0000, cpu_addr = 16'h0000;
    logic [7:0]  hs_wdata = 8'h00, cpu_wdata = 8'h00;
    logic        hs_gnt, ram_we, pause, dim_video;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner/phase flags plus the cycle at which the grant is due
    int cyc = 0;
    bit idle_m = 1'b1, gnt_m = 1'b0, rel_m = 1'b0;
    int grant_at_m = -1;
    bit tog_m = 1'b0, prev_m = 1'b0, pause_m = 1'b0, dim_m = 1'b0;
    int run_m = 0;

    hs_ram_arbiter #(
        .ADDR_W(16), .DATA_W(8), .SETTLE_CYC(SETTLE), .DIM_CYC(32'(DIM))
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .m_pause(m_pause), .osd_open(osd_open),
        .osd_pause_en(osd_pause_en), .vblank(vblank), .hs_req(hs_req), .hs_addr(hs_addr),
        .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_gnt(hs_gnt), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .pause(pause), .dim_video(dim_video)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit p_next;
        bit d_next;
        cyc++;
        if (reset) begin
            idle_m = 1'b1; gnt_m = 1'b0; rel_m = 1'b0; grant_at_m = -1;
            tog_m = 1'b0; prev_m = 1'b0; pause_m = 1'b0; dim_m = 1'b0; run_m = 0;
        end else begin
            p_next = !idle_m || tog_m || (osd_open && osd_pause_en);
            d_next = (run_m >= DIM);
            run_m  = pause_m ? ((run_m + 1 > DIM) ? DIM : run_m + 1) : 0;
            dim_m  = d_next;
            pause_m = p_next;
            if (m_pause && !prev_m) tog_m = !tog_m;
            prev_m = m_pause;
            if (idle_m) begin
                if (hs_req) begin
                    idle_m = 1'b0;
                    grant_at_m = -1;
                end
            end else if (rel_m) begin
                rel_m = 1'b0;
                idle_m = 1'b1;
            end else if (gnt_m) begin
                if (!hs_req) begin
                    gnt_m = 1'b0;
                    rel_m = 1'b1;
                end
            end else if (!hs_req) begin
                idle_m = 1'b1;
            end else if (grant_at_m < 0) begin
                if (vblank) grant_at_m = cyc + SETTLE;
            end else if (cyc == grant_at_m) begin
                gnt_m = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic exp_we;
        exp_we = reset ? 1'b0 : (idle_m ? cpu_we : (gnt_m ? hs_we : 1'b0));
        chk("hs_gnt", 32'(hs_gnt), 32'(gnt_m));
        chk("pause", 32'(pause), 32'(pause_m));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_addr", 32'(ram_addr), 32'(gnt_m ? hs_addr : cpu_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(gnt_m ? hs_wdata : cpu_wdata));
`ifdef PAUSE_DIM_EN
        chk("dim_video", 32'(dim_video), 32'(dim_m));
`else
        chk("dim_video", 32'(dim_video), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #2;
        check_all();
    endtask

    initial begin
        // Reset and plain CPU pass-through
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_gnt", 32'(hs_gnt), 32'd0);
        chk("rst_pause", 32'(pause), 32'd0);
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
        #1;
        chk("run_we", 32'(ram_we), 32'd1);
        chk("run_addr", 32'(ram_addr), 32'h1234);
        tick();

        // Grant latency with vblank already high
        vblank = 1'b1; hs_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lat_gnt_low", 32'(hs_gnt), 32'd0);
            chk("lat_we_block", 32'(ram_we), 32'd0);
        end
        tick();
        chk("lat_gnt_high", 32'(hs_gnt), 32'd1);

        // Hiscore write through the port, then release
        hs_we = 1'b1; hs_addr = 16'h0040; hs_wdata = 8'hA5;
        #1;
        chk("gnt_we", 32'(ram_we), 32'd1);
        chk("gnt_addr", 32'(ram_addr), 32'h0040);
        chk("gnt_wdata", 32'(ram_wdata), 32'hA5);
        tick();
        hs_req = 1'b0; hs_we = 1'b0;
        tick();
        chk("rel_gnt", 32'(hs_gnt), 32'd0);
        tick();
        chk("rel_pause_hold", 32'(pause), 32'd1);
        tick();
        chk("rel_pause_drop", 32'(pause), 32'd0);

        // Long drain waiting for vblank
        vblank = 1'b0; hs_req = 1'b1;
        repeat (100) tick();
        chk("drain_no_gnt", 32'(hs_gnt), 32'd0);
        vblank = 1'b1;
        repeat (4) tick();
        chk("vb_gnt_low", 32'(hs_gnt), 32'd0);
        tick();
        chk("vb_gnt_high", 32'(hs_gnt), 32'd1);
        hs_req = 1'b0;
        repeat (3) tick();

        // Request withdrawn during settle
        hs_req = 1'b1;
        repeat (3) tick();
        hs_req = 1'b0;
        repeat (6) tick();
        chk("abort_no_gnt", 32'(hs_gnt), 32'd0);
        chk("abort_pause", 32'(pause), 32'd0);

        // User pause toggle and OSD hold
        m_pause = 1'b1; repeat (3) tick(); m_pause = 1'b0; repeat (3) tick();
        chk("toggle_on", 32'(pause), 32'd1);
        m_pause = 1'b1; repeat (3) tick(); m_pause = 1'b0; repeat (3) tick();
        chk("toggle_off", 32'(pause), 32'd0);
        osd_open = 1'b1; osd_pause_en = 1'b0;
        repeat (3) tick();
        chk("osd_no_pause", 32'(pause), 32'd0);
        osd_pause_en = 1'b1;
        repeat (2) tick();
        chk("osd_pause", 32'(pause), 32'd1);
        osd_open = 1'b0; osd_pause_en = 1'b0;
        repeat (2) tick();

        // Long pause for the dim flag
        m_pause = 1'b1; tick(); m_pause = 1'b0;
        repeat (DIM + 6) tick();
`ifdef PAUSE_DIM_EN
        chk("dim_on", 32'(dim_video), 32'd1);
`else
        chk("dim_tied", 32'(dim_video), 32'd0);
`endif
        m_pause = 1'b1; tick(); m_pause = 1'b0;
        repeat (4) tick();
        chk("dim_off", 32'(dim_video), 32'd0);

        // Reset in the middle of a grant
        hs_req = 1'b1; vblank = 1'b1;
        repeat (6) tick();
        chk("pre_rst_gnt", 32'(hs_gnt), 32'd1);
        hs_we = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_cycle_we", 32'(ram_we), 32'd0);
        tick();
        chk("rst_gnt_clr", 32'(hs_gnt), 32'd0);
        reset = 1'b0; hs_req = 1'b0; hs_we = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) hs_req = ~hs_req;
            vblank    = ($urandom_range(3) == 0);
            hs_we     = 1'($urandom);
            hs_addr   = 16'($urandom);
            hs_wdata  = 8'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            if ($urandom_range(19) == 0) m_pause = ~m_pause;
            if ($urandom_range(29) == 0) osd_open = ~osd_open;
            if ($urandom_range(39) == 0) osd_pause_en = ~osd_pause_en;
            reset = ($urandom_range(199) == 0);
            #1;
            check_all();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
